s_term_uturn_cfg: RTL and testbench
===================================

// Module: s_term_uturn_cfg
// PURPOSE
//  Parametrised south-edge termination tile. It sits at the bottom of a fabric column.
//  It loops every southbound wire (S1/S2MID/S2/S4) back onto its northbound twin
//  (N1/N2/N2b/N4) under per-wire frame configuration.
//  The U-turn for each wire is one of four modes: tied 0, combinational, registered, or tied 1.
//  FrameData/FrameStrobe are forwarded up the column, optionally through one pipeline stage.
// PARAMETERS
//  FRAME_BITS   32  width of FrameData per row
//  MAX_FRAMES   20  width of FrameStrobe per column
//  N_SINGLE      4  single-span wires (S1END->N1BEG)
//  N_DOUBLE      8  double-span wires per half (S2MID->N2BEG, S2END->N2BEGb)
//  N_QUAD       16  quad-span wires (S4END->N4BEG)
//  FRAME_PIPE    1  0: frame forward combinational; 1: one register stage
//  Derived: N_OUT=N_SINGLE+2*N_DOUBLE+N_QUAD (36), CFG_BITS=2*N_OUT (72),
//           CFG_FRAMES=ceil(CFG_BITS/FRAME_BITS) (3); requires CFG_FRAMES<=MAX_FRAMES
// PORTS
//  UserCLK        in   1           tile clock
//  resetn         in   1           synchronous reset, active-low
//  S1END          in   N_SINGLE    southbound singles
//  S2MID          in   N_DOUBLE    southbound doubles, mid tap
//  S2END          in   N_DOUBLE    southbound doubles, end tap
//  S4END          in   N_QUAD      southbound quads
//  N1BEG          out  N_SINGLE    northbound singles
//  N2BEG          out  N_DOUBLE    northbound doubles
//  N2BEGb         out  N_DOUBLE    northbound doubles, second half
//  N4BEG          out  N_QUAD      northbound quads
//  FrameData      in   FRAME_BITS  config frame data
//  FrameStrobe    in   MAX_FRAMES  per-frame write strobes
//  FrameData_O    out  FRAME_BITS  forwarded FrameData
//  FrameStrobe_O  out  MAX_FRAMES  forwarded FrameStrobe
// BEHAVIOUR
//  - Flat vectors, with index 0 as the LSB of each:
//    IN  = {S4END, S2END, S2MID, S1END}
//    OUT = {N4BEG, N2BEGb, N2BEG, N1BEG}
//    OUT[j] is driven from IN[j].
//  - Config store: CFG_FRAMES regs cfg_f[k] of FRAME_BITS each.
//    cfg = {cfg_f[CFG_FRAMES-1], ..., cfg_f[0]}; mode[j] = cfg[2j+1:2j].
//    Bits at or above CFG_BITS are stored but ignored.
//  - Write: at UserCLK rise, if resetn=1 and FrameStrobe[k]=1 (k<CFG_FRAMES),
//    then cfg_f[k] <= FrameData. New mode is visible from the next cycle.
//    Multiple strobes in one cycle: every strobed frame gets the same data.
//    FrameStrobe[k] for k>=CFG_FRAMES is forwarded only.
//  - mode 00: OUT[j]=0.
//    mode 01: OUT[j]=IN[j], combinational, 0 latency.
//    mode 10: OUT[j]=uturn_q[j]; uturn_q[j]<=IN[j] every cycle, 1-cycle latency.
//    mode 11: OUT[j]=1.
//  - uturn_q captures every cycle regardless of mode. Switching 01->10 therefore
//    shows the previous-cycle IN with no stale history.
//  - Frame forward:
//    FRAME_PIPE=0: FrameData_O=FrameData, FrameStrobe_O=FrameStrobe (buffered wires).
//    FRAME_PIPE=1: both are registered, 1-cycle latency, every strobe bit included.
//  - Reset (resetn=0 at clock edge): all cfg_f<=0, uturn_q<=0, frame pipe regs<=0.
//    Reset wins over a simultaneous strobe.
//    After reset every N*BEG=0 (mode 00).
//    FrameData_O/FrameStrobe_O are 0 when FRAME_PIPE=1; pass-through when FRAME_PIPE=0.
//  - Reset mid-operation: config is lost; the column must be re-written.
// TESTING
//  1 Reset: resetn=0 for 2 clks with S*=all-1 and FrameStrobe=all-1
//    -> N*BEG all 0, FrameStrobe_O=0 (PIPE=1), cfg unchanged at 0.
//  2 Write frame0=0x55555555 (all mode 01), S1END=4'hA
//    -> N1BEG=4'hA in the same cycle from the cycle after the write.
//    S1END toggles -> N1BEG follows combinationally.
//  3 Write frame0=0xAAAAAAAA (mode 10), drive S1END 1,2,3 on successive cycles
//    -> N1BEG 1,2,3 delayed by exactly 1 clk.
//  4 Frames 1/2 = 0xFFFFFFFF (mode 11 on outputs 16..35), S4END=0
//    -> N4BEG=16'hFFFF and N2BEGb[7:0]=8'hFF.
//    Frame2 bit 8 and above are don't-care.
//  5 FrameStrobe=20'h00005 with FrameData=0x12345678
//    -> cfg_f0 and cfg_f2 written, cfg_f1 kept.
//    FrameStrobe_O=20'h00005, FrameData_O=0x12345678 one clk later (PIPE=1).
//  6 Strobe asserted in the same cycle as resetn=0 -> no write, cfg stays 0.
//    Repeat 2-5 with FRAME_PIPE=0 and N_QUAD=8: widths and latency adapt.

Source files
------------

// File: rtl/s_term_uturn_cfg_if.sv
// Port bundle for the south termination tile: the U-turn wires plus the
// configuration frame bus entering from below and leaving towards the north.
interface s_term_uturn_cfg_if #(
  parameter int FRAME_BITS = 32,
  parameter int MAX_FRAMES = 20,
  parameter int N_SINGLE   = 4,
  parameter int N_DOUBLE   = 8,
  parameter int N_QUAD     = 16
);
  logic [N_SINGLE-1:0]   S1END;
  logic [N_DOUBLE-1:0]   S2MID;
  logic [N_DOUBLE-1:0]   S2END;
  logic [N_QUAD-1:0]     S4END;
  logic [N_SINGLE-1:0]   N1BEG;
  logic [N_DOUBLE-1:0]   N2BEG;
  logic [N_DOUBLE-1:0]   N2BEGb;
  logic [N_QUAD-1:0]     N4BEG;
  logic [FRAME_BITS-1:0] FrameData;
  logic [MAX_FRAMES-1:0] FrameStrobe;
  logic [FRAME_BITS-1:0] FrameData_O;
  logic [MAX_FRAMES-1:0] FrameStrobe_O;

  // Fabric side: drives southbound wires and frames, sees the loopback.
  modport master (
    output S1END, S2MID, S2END, S4END, FrameData, FrameStrobe,
    input  N1BEG, N2BEG, N2BEGb, N4BEG, FrameData_O, FrameStrobe_O
  );

  // Tile side.
  modport slave (
    input  S1END, S2MID, S2END, S4END, FrameData, FrameStrobe,
    output N1BEG, N2BEG, N2BEGb, N4BEG, FrameData_O, FrameStrobe_O
  );
endinterface

// File: rtl/s_term_uturn_cfg.sv
// South-edge termination tile: every southbound wire is looped back onto its
// northbound twin through a per-wire 2-bit mode (0 / comb / registered / 1).
// Modes live in frame-written config registers; frames are forwarded north.

// One U-turn lane. The capture register runs every cycle independent of the
// mode so that switching into registered mode never exposes stale history.
module s_term_uturn_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       din,
  output logic       dout
);
  logic q;

  // Previous-cycle copy of the southbound wire.
  always_ff @(posedge clk) begin
    if (!rst_n) q <= 1'b0;
    else        q <= din;
  end

  // Output select by mode.
  always_comb begin
    dout = 1'b0;
    case (mode)
      2'b00:   dout = 1'b0;
      2'b01:   dout = din;
      2'b10:   dout = q;
      default: dout = 1'b1;
    endcase
  end
endmodule

module s_term_uturn_cfg #(
  parameter int FRAME_BITS = 32,
  parameter int MAX_FRAMES = 20,
  parameter int N_SINGLE   = 4,
  parameter int N_DOUBLE   = 8,
  parameter int N_QUAD     = 16,
  parameter int FRAME_PIPE = 1
) (
  input  logic                UserCLK,
  input  logic                resetn,
  s_term_uturn_cfg_if.slave   bus
);
  localparam int N_OUT      = N_SINGLE + 2*N_DOUBLE + N_QUAD;
  localparam int CFG_BITS   = 2*N_OUT;
  localparam int CFG_FRAMES = (CFG_BITS + FRAME_BITS - 1) / FRAME_BITS;
  localparam int STORE_BITS = CFG_FRAMES*FRAME_BITS;

  // cfg_f[0] occupies the low bits of the flattened config word.
  logic [CFG_FRAMES-1:0][FRAME_BITS-1:0] cfg_f;
  logic [STORE_BITS-1:0]                 cfg;
  logic [N_OUT-1:0][1:0]                 mode;
  logic [N_OUT-1:0]                      in_vec;
  logic [N_OUT-1:0]                      out_vec;

  // Frame writes; reset takes priority, several strobes share one data word.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      cfg_f <= '0;
    end else begin
      for (int k = 0; k < CFG_FRAMES; k++)
        if (bus.FrameStrobe[k]) cfg_f[k] <= bus.FrameData;
    end
  end

  assign cfg  = cfg_f;
  assign mode = cfg[CFG_BITS-1:0];

  // Padding bits in the last frame are stored but select nothing.
  if (STORE_BITS > CFG_BITS) begin : g_spare
    logic spare_unused;
    assign spare_unused = ^cfg[STORE_BITS-1:CFG_BITS];
  end

  assign in_vec = {bus.S4END, bus.S2END, bus.S2MID, bus.S1END};

  s_term_uturn_lane u_lane [N_OUT-1:0] (
    .clk   (UserCLK),
    .rst_n (resetn),
    .mode  (mode),
    .din   (in_vec),
    .dout  (out_vec)
  );

  assign bus.N1BEG  = out_vec[N_SINGLE-1:0];
  assign bus.N2BEG  = out_vec[N_SINGLE+N_DOUBLE-1:N_SINGLE];
  assign bus.N2BEGb = out_vec[N_SINGLE+2*N_DOUBLE-1:N_SINGLE+N_DOUBLE];
  assign bus.N4BEG  = out_vec[N_OUT-1:N_SINGLE+2*N_DOUBLE];

  if (FRAME_PIPE != 0) begin : g_pipe
    logic [FRAME_BITS-1:0] fd_q;
    logic [MAX_FRAMES-1:0] fs_q;

    // One retiming stage on the column frame bus, all strobe bits included.
    always_ff @(posedge UserCLK) begin
      if (!resetn) begin
        fd_q <= '0;
        fs_q <= '0;
      end else begin
        fd_q <= bus.FrameData;
        fs_q <= bus.FrameStrobe;
      end
    end

    assign bus.FrameData_O   = fd_q;
    assign bus.FrameStrobe_O = fs_q;
  end else begin : g_wire
    assign bus.FrameData_O   = bus.FrameData;
    assign bus.FrameStrobe_O = bus.FrameStrobe;
  end
endmodule

// File: tb/tb_s_term_uturn_cfg.sv
// Bench for the south termination tile: a pipelined 16-quad instance driven
// from a vector table, and a combinational-forward 8-quad instance driven by
// a short hand-written sequence.
module tb_s_term_uturn_cfg;
  logic UserCLK = 1'b0;
  logic resetn  = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  always #5 UserCLK = ~UserCLK;

  s_term_uturn_cfg_if #(.N_QUAD(16)) if_a ();
  s_term_uturn_cfg_if #(.N_QUAD(8))  if_b ();

  s_term_uturn_cfg #(.N_QUAD(16), .FRAME_PIPE(1)) dut_a (
    .UserCLK (UserCLK),
    .resetn  (resetn),
    .bus     (if_a)
  );

  s_term_uturn_cfg #(.N_QUAD(8), .FRAME_PIPE(0)) dut_b (
    .UserCLK (UserCLK),
    .resetn  (resetn),
    .bus     (if_b)
  );

  typedef struct {
    logic [19:0] st;
    logic [31:0] fd;
    logic [3:0]  s1;
    logic [7:0]  s2m;
    logic [7:0]  s2e;
    logic [15:0] s4;
    logic [3:0]  n1;
    logic [7:0]  n2;
    logic [7:0]  n2b;
    logic [15:0] n4;
  } vec_t;

  typedef struct {
    logic [3:0]  n1;
    logic [7:0]  n2;
    logic [7:0]  n2b;
    logic [15:0] n4;
  } exp_t;

  typedef struct {
    logic [19:0] st;
    logic [31:0] fd;
  } frm_t;

  vec_t tbl [12];
  exp_t exp_q [$];
  frm_t frm_q [$];

  function automatic vec_t mk(
    input logic [19:0] st, input logic [31:0] fd,
    input logic [3:0] s1, input logic [7:0] s2m, input logic [7:0] s2e,
    input logic [15:0] s4,
    input logic [3:0] n1, input logic [7:0] n2, input logic [7:0] n2b,
    input logic [15:0] n4);
    vec_t v;
    v.st = st; v.fd = fd; v.s1 = s1; v.s2m = s2m; v.s2e = s2e; v.s4 = s4;
    v.n1 = n1; v.n2 = n2; v.n2b = n2b; v.n4 = n4;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic [19:0] st, input logic [31:0] fd,
                         input logic [3:0] s1, input logic [7:0] s2m,
                         input logic [7:0] s2e, input logic [15:0] s4);
    if_a.FrameStrobe = st; if_a.FrameData = fd;
    if_a.S1END = s1; if_a.S2MID = s2m; if_a.S2END = s2e; if_a.S4END = s4;
  endtask

  task automatic drive_b(input logic [19:0] st, input logic [31:0] fd,
                         input logic [3:0] s1, input logic [7:0] s2m,
                         input logic [7:0] s2e, input logic [7:0] s4);
    if_b.FrameStrobe = st; if_b.FrameData = fd;
    if_b.S1END = s1; if_b.S2MID = s2m; if_b.S2END = s2e; if_b.S4END = s4;
  endtask

  task automatic next_cycle();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic chk_a_zero(input string nm);
    chk({nm, " N1BEG"},  64'(if_a.N1BEG),  64'h0);
    chk({nm, " N2BEG"},  64'(if_a.N2BEG),  64'h0);
    chk({nm, " N2BEGb"}, 64'(if_a.N2BEGb), 64'h0);
    chk({nm, " N4BEG"},  64'(if_a.N4BEG),  64'h0);
    chk({nm, " FrameStrobe_O"}, 64'(if_a.FrameStrobe_O), 64'h0);
    chk({nm, " FrameData_O"},   64'(if_a.FrameData_O),   64'h0);
  endtask

  initial begin
    exp_t e;
    frm_t f;

    // st, fd, s1, s2m, s2e, s4  ->  n1, n2, n2b, n4
    tbl[0]  = mk(20'h1, 32'h55555555, 4'hA, 8'h00, 8'h00, 16'h0000, 4'h0, 8'h00, 8'h00, 16'h0000);
    tbl[1]  = mk(20'h0, 32'h0,        4'hA, 8'h3C, 8'hF5, 16'h0000, 4'hA, 8'h3C, 8'h05, 16'h0000);
    tbl[2]  = mk(20'h0, 32'h0,        4'h5, 8'hC3, 8'h0A, 16'h0000, 4'h5, 8'hC3, 8'h0A, 16'h0000);
    tbl[3]  = mk(20'h1, 32'hAAAAAAAA, 4'h1, 8'h00, 8'h00, 16'h0000, 4'h1, 8'h00, 8'h00, 16'h0000);
    tbl[4]  = mk(20'h0, 32'h0,        4'h2, 8'hFF, 8'hFF, 16'h0000, 4'h1, 8'h00, 8'h00, 16'h0000);
    tbl[5]  = mk(20'h0, 32'h0,        4'h3, 8'h00, 8'h00, 16'h0000, 4'h2, 8'hFF, 8'h0F, 16'h0000);
    tbl[6]  = mk(20'h0, 32'h0,        4'h0, 8'h00, 8'h00, 16'h0000, 4'h3, 8'h00, 8'h00, 16'h0000);
    tbl[7]  = mk(20'h6, 32'hFFFFFFFF, 4'h0, 8'h00, 8'h0F, 16'h0000, 4'h0, 8'h00, 8'h00, 16'h0000);
    tbl[8]  = mk(20'h0, 32'h0,        4'h0, 8'h00, 8'h00, 16'h0000, 4'h0, 8'h00, 8'hFF, 16'hFFFF);
    tbl[9]  = mk(20'h5, 32'h12345678, 4'h0, 8'h00, 8'h00, 16'h0000, 4'h0, 8'h00, 8'hF0, 16'hFFFF);
    tbl[10] = mk(20'h0, 32'h0,        4'hF, 8'hFF, 8'hFF, 16'hFFFF, 4'hC, 8'h6E, 8'hF4, 16'hCFFF);
    tbl[11] = mk(20'h0, 32'h0,        4'h0, 8'h00, 8'h00, 16'h0000, 4'h6, 8'h41, 8'hF1, 16'h6FFF);

    // Reset with every input high and every strobe asserted.
    drive_a('1, '1, '1, '1, '1, '1);
    drive_b('0, '0, '0, '0, '0, '0);
    resetn = 1'b0;
    next_cycle();
    next_cycle();
    chk_a_zero("reset");

    // Out of reset, nothing written: config must still be all mode 00.
    resetn = 1'b1;
    drive_a('0, '0, '1, '1, '1, '1);
    @(negedge UserCLK);
    chk_a_zero("post-reset cfg");
    next_cycle();
    f.st = '0; f.fd = '0;
    frm_q.push_back(f);

    // Vector table on the pipelined instance.
    for (int i = 0; i < 12; i++) begin
      drive_a(tbl[i].st, tbl[i].fd, tbl[i].s1, tbl[i].s2m, tbl[i].s2e, tbl[i].s4);
      e.n1 = tbl[i].n1; e.n2 = tbl[i].n2; e.n2b = tbl[i].n2b; e.n4 = tbl[i].n4;
      exp_q.push_back(e);
      @(negedge UserCLK);
      e = exp_q.pop_front();
      chk($sformatf("row%0d N1BEG", i),  64'(if_a.N1BEG),  64'(e.n1));
      chk($sformatf("row%0d N2BEG", i),  64'(if_a.N2BEG),  64'(e.n2));
      chk($sformatf("row%0d N2BEGb", i), 64'(if_a.N2BEGb), 64'(e.n2b));
      chk($sformatf("row%0d N4BEG", i),  64'(if_a.N4BEG),  64'(e.n4));
      f = frm_q.pop_front();
      chk($sformatf("row%0d FrameStrobe_O", i), 64'(if_a.FrameStrobe_O), 64'(f.st));
      chk($sformatf("row%0d FrameData_O", i),   64'(if_a.FrameData_O),   64'(f.fd));
      f.st = tbl[i].st; f.fd = tbl[i].fd;
      frm_q.push_back(f);
      next_cycle();
    end
    frm_q.delete();

    // Strobe coincident with reset: the write must be dropped.
    resetn = 1'b0;
    drive_a(20'h7, 32'hFFFFFFFF, '0, '0, '0, '0);
    next_cycle();
    resetn = 1'b1;
    drive_a('0, '0, '1, '1, '1, '1);
    @(negedge UserCLK);
    chk_a_zero("reset vs strobe");
    next_cycle();

    // Combinational-forward, 8-quad instance.
    drive_b(20'h1, 32'h55555555, 4'h0, 8'h00, 8'h00, 8'h00);
    @(negedge UserCLK);
    chk("B FrameData_O comb",   64'(if_b.FrameData_O),   64'h55555555);
    chk("B FrameStrobe_O comb", 64'(if_b.FrameStrobe_O), 64'h1);
    chk("B N1BEG before write", 64'(if_b.N1BEG),         64'h0);
    next_cycle();

    drive_b(20'h2, 32'hAAAAAAAA, 4'hA, 8'h00, 8'h00, 8'h00);
    @(negedge UserCLK);
    chk("B N1BEG comb", 64'(if_b.N1BEG), 64'hA);
    next_cycle();

    drive_b(20'h4, 32'hFFFFFFFF, 4'hA, 8'h00, 8'hF0, 8'h5A);
    @(negedge UserCLK);
    chk("B FrameStrobe_O fwd-only", 64'(if_b.FrameStrobe_O), 64'h4);
    chk("B N4BEG reg first",        64'(if_b.N4BEG),         64'h00);
    chk("B N2BEGb reg first",       64'(if_b.N2BEGb),        64'h00);
    next_cycle();

    drive_b(20'h0, 32'h0, 4'hA, 8'h00, 8'h00, 8'h00);
    @(negedge UserCLK);
    chk("B N4BEG reg latency",  64'(if_b.N4BEG),  64'h5A);
    chk("B N2BEGb mixed",       64'(if_b.N2BEGb), 64'hF0);
    chk("B N1BEG held",         64'(if_b.N1BEG),  64'hA);
    next_cycle();

    @(negedge UserCLK);
    chk("B N4BEG drained", 64'(if_b.N4BEG), 64'h00);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
